// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the IFU/LSU request ports, the arbiter and the shared memory port.
// The slave modport is the arbiter's view; master is the core/memory environment.
interface mem_port_arbiter_if;
  logic        ifu_reqValid;
  logic [31:0] ifu_addr;
  logic        ifu_respValid;
  logic [31:0] ifu_rdata;

  logic        lsu_reqValid;
  logic [31:0] lsu_addr;
  logic [1:0]  lsu_size;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_respValid;
  logic [31:0] lsu_rdata;

  logic        mem_reqValid;
  logic [31:0] mem_addr;
  logic [1:0]  mem_size;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_respValid;
  logic [31:0] mem_rdata;

  logic        timeout_err;

  modport slave (
    input  ifu_reqValid, ifu_addr,
    output ifu_respValid, ifu_rdata,
    input  lsu_reqValid, lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_respValid, lsu_rdata,
    output mem_reqValid, mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask,
    input  mem_respValid, mem_rdata,
    output timeout_err
  );

  modport master (
    output ifu_reqValid, ifu_addr,
    input  ifu_respValid, ifu_rdata,
    output lsu_reqValid, lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_respValid, lsu_rdata,
    input  mem_reqValid, mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask,
    output mem_respValid, mem_rdata,
    input  timeout_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IFU fetch and LSU data requests: grants one, latches it,
// holds it on the port until the response (or a timeout abort) and routes the reply back.
module mem_port_arbiter #(
  parameter int unsigned LSU_FIRST   = 1,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned CNT_W       = 11
) (
  input logic             clock,
  input logic             reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_BUSY_IFU = 2'd1;
  localparam logic [1:0] S_BUSY_LSU = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [31:0]      addr_q,  addr_d;
  logic [1:0]       size_q,  size_d;
  logic             wen_q,   wen_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wmask_q, wmask_d;

  logic busy;
  logic expire;
  logic finish;
  logic pick_lsu;

  always_comb begin
    busy     = (state_q != S_IDLE);
    // A response arriving in the last allowed cycle takes priority over the abort.
    expire   = busy && !bus.mem_respValid && (cnt_q == CNT_LAST);
    finish   = busy && (bus.mem_respValid || expire);
    pick_lsu = bus.lsu_reqValid && ((LSU_FIRST != 0) || !bus.ifu_reqValid);

    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;

    case (state_q)
      S_IDLE: begin
        if (bus.ifu_reqValid || bus.lsu_reqValid) begin
          cnt_d = '0;
          if (pick_lsu) begin
            state_d = S_BUSY_LSU;
            addr_d  = bus.lsu_addr;
            size_d  = bus.lsu_size;
            wen_d   = bus.lsu_wen;
            wdata_d = bus.lsu_wdata;
            wmask_d = bus.lsu_wmask;
          end else begin
            state_d = S_BUSY_IFU;
            addr_d  = bus.ifu_addr;
            size_d  = 2'b10;
            wen_d   = 1'b0;
            wdata_d = '0;
            wmask_d = '0;
          end
        end
      end
      S_BUSY_IFU, S_BUSY_LSU: begin
        if (finish) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

  // Shared-port fields come straight from registers, so no request input reaches them.
  assign bus.mem_reqValid = busy;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_size     = size_q;
  assign bus.mem_wen      = wen_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.mem_wmask    = wmask_q;

  assign bus.ifu_respValid = finish && (state_q == S_BUSY_IFU);
  assign bus.lsu_respValid = finish && (state_q == S_BUSY_LSU);
  assign bus.ifu_rdata     = (bus.ifu_respValid && bus.mem_respValid) ? bus.mem_rdata : '0;
  assign bus.lsu_rdata     = (bus.lsu_respValid && bus.mem_respValid) ? bus.mem_rdata : '0;
  assign bus.timeout_err   = expire;

endmodule
